// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M-style multiply/divide unit. It uses a shift-add
//            multiplier and a restoring divider, and every op completes in
//            exactly WIDTH cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_q;
    logic               rneg_q;
    logic               dz_q;
    logic               valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;

    logic               a_signed_d;
    logic               b_signed_d;
    logic               a_neg_d;
    logic               b_neg_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     shift_d;
    logic               ge_d;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [2*WIDTH-1:0] prod_fix_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   res_d;

    // Operand signedness and magnitudes are taken from the request bus.
    always_comb begin
        a_signed_d = 1'b0;
        b_signed_d = 1'b0;
        case (in_op)
            OP_MULH:   begin a_signed_d = 1'b1; b_signed_d = 1'b1; end
            OP_MULHSU: begin a_signed_d = 1'b1; b_signed_d = 1'b0; end
            OP_DIV,
            OP_REM:    begin a_signed_d = 1'b1; b_signed_d = 1'b1; end
            default:   begin a_signed_d = 1'b0; b_signed_d = 1'b0; end
        endcase
        a_neg_d = a_signed_d & in_a[WIDTH-1];
        b_neg_d = b_signed_d & in_b[WIDTH-1];
        a_mag_d = a_neg_d ? -in_a : in_a;
        b_mag_d = b_neg_d ? -in_b : in_b;
    end

    // One iteration step. {hi_q, lo_q} holds the partial product or the
    // partial remainder and quotient. mcand_q holds the multiplicand or the divisor.
    always_comb begin
        sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        shift_d = {hi_q, lo_q[WIDTH-1]};
        ge_d    = (shift_d >= {1'b0, mcand_q});
        if (op_q[2]) begin
            hi_d = ge_d ? WIDTH'(shift_d - {1'b0, mcand_q}) : shift_d[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge_d};
        end else begin
            hi_d = sum_d[WIDTH:1];
            lo_d = {sum_d[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the value produced by the final step.
    always_comb begin
        prod_d     = {hi_d, lo_d};
        prod_fix_d = neg_q ? -prod_d : prod_d;
        quot_d     = neg_q ? -lo_d : lo_d;
        rem_d      = rneg_q ? -hi_d : hi_d;
        case (op_q)
            OP_MUL:    res_d = prod_fix_d[WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  res_d = prod_fix_d[2*WIDTH-1:WIDTH];
            OP_DIV,
            OP_DIVU:   res_d = dz_q ? {WIDTH{1'b1}} : quot_d;
            OP_REM,
            OP_REMU:   res_d = rem_d;
            default:   res_d = {WIDTH{1'b0}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 3'b000;
            mcand_q  <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
        end else if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_op;
                        mcand_q <= in_op[2] ? b_mag_d : a_mag_d;
                        lo_q    <= in_op[2] ? a_mag_d : b_mag_d;
                        hi_q    <= {WIDTH{1'b0}};
                        neg_q   <= a_neg_d ^ b_neg_d;
                        rneg_q  <= a_neg_d;
                        dz_q    <= (in_b == {WIDTH{1'b0}});
                        cnt_q   <= CNT_W'(WIDTH);
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= res_d;
                        zero_q   <= (res_d == {WIDTH{1'b0}});
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;

    logic        flush32, v32, rdy32, ov32, ordy32, z32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        flush8, v8, rdy8, ov8, ordy8, z8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32),
        .in_valid(v32), .in_ready(rdy32), .in_op(op32), .in_a(a32), .in_b(b32),
        .out_valid(ov32), .out_ready(ordy32), .out_result(res32), .out_zero(z32)
    );

    muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(v8), .in_ready(rdy8), .in_op(op8), .in_a(a8), .in_b(b8),
        .out_valid(ov8), .out_ready(ordy8), .out_result(res8), .out_zero(z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          w8;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sel_res(input bit w8);
        return w8 ? {24'd0, res8} : res32;
    endfunction

    task automatic run_op(input bit w8, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string nm);
        int edges;
        int lat;
        lat = w8 ? 8 : 32;
        @(negedge clk);
        if (w8) begin v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else    begin v32 = 1'b1; op32 = op; a32 = a; b32 = b; end
        check({nm, " in_ready before accept"}, {31'd0, (w8 ? rdy8 : rdy32)}, 32'd1);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v32 = 1'b0;
        edges = 0;
        while (!(w8 ? ov8 : ov32) && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({nm, " latency"}, edges, lat);
        check({nm, " result"}, sel_res(w8), exp);
        check({nm, " zero"}, {31'd0, (w8 ? z8 : z32)}, {31'd0, (exp == 32'd0)});
        @(negedge clk);
        if (w8) ordy8 = 1'b1; else ordy32 = 1'b1;
        @(posedge clk);
        #1;
        ordy8  = 1'b0;
        ordy32 = 1'b0;
        check({nm, " valid drop"}, {31'd0, (w8 ? ov8 : ov32)}, 32'd0);
    endtask

    task automatic wait_valid32(input string nm);
        int edges;
        edges = 0;
        while (!ov32 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({nm, " valid seen"}, {31'd0, ov32}, 32'd1);
    endtask

    initial begin
        bool_t_dummy_init();
    end

    function automatic void bool_t_dummy_init();
    endfunction

    initial begin
        bit never_valid;
        rst_n = 1'b0;
        flush32 = 1'b0; v32 = 1'b0; ordy32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
        flush8  = 1'b0; v8  = 1'b0; ordy8  = 1'b0; op8  = 3'd0; a8  = '0; b8  = '0;

        vecs.push_back('{0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul 7*-3"});
        vecs.push_back('{0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh min*min"});
        vecs.push_back('{0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu max*max"});
        vecs.push_back('{0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu -1*max"});
        vecs.push_back('{0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh -1*-1"});
        vecs.push_back('{0, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulh -1*2"});
        vecs.push_back('{0, 3'b000, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, "mul zero"});
        vecs.push_back('{0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div -7/2"});
        vecs.push_back('{0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem -7/2"});
        vecs.push_back('{0, 3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div 7/-2"});
        vecs.push_back('{0, 3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "rem 7/-2"});
        vecs.push_back('{0, 3'b101, 32'd100,       32'd7,         32'd14,        "divu 100/7"});
        vecs.push_back('{0, 3'b111, 32'd100,       32'd7,         32'd2,         "remu 100/7"});
        vecs.push_back('{0, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, "divu max/1"});
        vecs.push_back('{0, 3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div 5/0"});
        vecs.push_back('{0, 3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div -7/0"});
        vecs.push_back('{0, 3'b111, 32'd5,         32'd0,         32'd5,         "remu 5/0"});
        vecs.push_back('{0, 3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem -7/0"});
        vecs.push_back('{0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div overflow"});
        vecs.push_back('{0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem overflow"});
        vecs.push_back('{1, 3'b000, 32'h0F,        32'h11,        32'hFF,        "w8 mul 0f*11"});
        vecs.push_back('{1, 3'b100, 32'h80,        32'hFF,        32'h80,        "w8 div overflow"});
        vecs.push_back('{1, 3'b110, 32'h80,        32'hFF,        32'h00,        "w8 rem overflow"});
        vecs.push_back('{1, 3'b011, 32'hFF,        32'hFF,        32'hFE,        "w8 mulhu ff*ff"});
        vecs.push_back('{1, 3'b100, 32'h05,        32'h00,        32'hFF,        "w8 div 5/0"});

        #12;
        check("reset out_valid",  {31'd0, ov32}, 32'd0);
        check("reset out_result", res32, 32'd0);
        check("reset out_zero",   {31'd0, z32}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready",   {31'd0, rdy32}, 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

        // DONE hold with out_ready low, with a competing request that must be ignored.
        @(negedge clk);
        v32 = 1'b1; op32 = 3'b000; a32 = 32'd3; b32 = 32'd5;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        wait_valid32("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v32 = 1'b1; op32 = 3'b101; a32 = 32'd99; b32 = 32'd9;
            @(posedge clk);
            #1;
            check("hold out_valid", {31'd0, ov32}, 32'd1);
            check("hold out_result", res32, 32'd15);
            check("hold in_ready", {31'd0, rdy32}, 32'd0);
        end
        @(negedge clk);
        v32 = 1'b0;
        ordy32 = 1'b1;
        @(posedge clk);
        #1;
        ordy32 = 1'b0;
        check("hold release valid", {31'd0, ov32}, 32'd0);
        check("hold release in_ready", {31'd0, rdy32}, 32'd1);

        // Flush during BUSY after ten steps.
        @(negedge clk);
        v32 = 1'b1; op32 = 3'b101; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        check("flush in_ready", {31'd0, rdy32}, 32'd1);
        check("flush out_valid", {31'd0, ov32}, 32'd0);
        check("flush result kept", res32, 32'd15);
        never_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ov32) never_valid = 1'b0;
        end
        check("flush valid never rises", {31'd0, never_valid}, 32'd1);

        // flush together with in_valid in IDLE: request must be dropped.
        @(negedge clk);
        v32 = 1'b1; flush32 = 1'b1; op32 = 3'b000; a32 = 32'd2; b32 = 32'd2;
        @(posedge clk);
        #1;
        v32 = 1'b0; flush32 = 1'b0;
        check("flush+valid not accepted", {31'd0, rdy32}, 32'd1);
        for (int i = 0; i < 34; i++) begin
            @(posedge clk);
            #1;
        end
        check("flush+valid no result", {31'd0, ov32}, 32'd0);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        v32 = 1'b1; op32 = 3'b000; a32 = 32'd7; b32 = 32'd7;
        @(posedge clk);
        #1;
        v32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'd0, ov32}, 32'd0);
        check("async rst out_result", res32, 32'd0);
        check("async rst out_zero", {31'd0, z32}, 32'd1);
        check("async rst in_ready", {31'd0, rdy32}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 3'b000, 32'd7, 32'd7, 32'd49, "post-reset mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, iterative multiply/divide execution unit implementing the RV32M operation set, generalised to WIDTH-bit operands.
- Sits beside the single-cycle ALU in the execute stage and handles the long-latency M-extension ops.
- Valid/ready handshake on input and output; one operation in flight; fixed latency.
- Registered result and zero flag match ALU result semantics.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 8.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; drops any op in flight
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept; high only in IDLE
- in_op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  input  WIDTH  operand 1 (rs1 / dividend)
- in_b  input  WIDTH  operand 2 (rs2 / divisor)
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  result
- out_zero  output  1  out_result == 0

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, counter = 0.
  - out_valid = 0, out_result = 0, out_zero = 1, in_ready = 1 after release.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - Acceptance edge E0 (in_valid & in_ready): latch op and operands, convert operands to magnitudes per op signedness, record result sign, counter = WIDTH, go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each edge performs one step: shift-add multiply (2*WIDTH-bit product) or restoring divide (one quotient bit); counter decrements.
  - On the edge where counter reaches 0 (edge E_WIDTH): apply sign correction, register out_result and out_zero, go to DONE.
  - Latency: out_valid is high in the cycle after E_WIDTH, i.e. exactly WIDTH edges after acceptance, for every op and every operand value.
- DONE:
  - out_valid = 1; out_result and out_zero stable.
  - out_ready high at an edge -> IDLE, out_valid = 0 next cycle.
  - No new op is accepted while in DONE.
  - Maximum throughput: one op per WIDTH+2 cycles.
- Signedness:
  - MUL: low WIDTH bits of the product.
  - MULH: high WIDTH bits, signed x signed.
  - MULHSU: high WIDTH bits, signed a x unsigned b.
  - MULHU: high WIDTH bits, unsigned x unsigned.
  - DIV/REM: signed, quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero:
  - DIV/DIVU return all ones.
  - REM/REMU return in_a unchanged.
  - No exception raised; latency still WIDTH.
- Signed overflow (in_a = most-negative, in_b = all ones):
  - DIV returns the most-negative value.
  - REM returns 0.
- flush:
  - Synchronous; higher priority than every other event except reset.
  - In any state, the next edge goes to IDLE with out_valid = 0; out_result keeps its last value.
  - flush with in_valid in IDLE: the request is not accepted.
- Reset asserted mid-operation: the op is lost immediately; all outputs take reset values.
- in_a, in_b and in_op are ignored outside the acceptance edge.

Test Plan:
- WIDTH=32, MUL a=7, b=0xFFFFFFFD -> out_result 0xFFFFFFEB, out_zero 0, out_valid exactly 32 edges after accept.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Edge cases:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0, out_zero 1.
- Handshake and abort:
  - Hold out_ready low 5 cycles in DONE -> out_valid and out_result stable, in_ready 0 throughout.
  - Assert flush at BUSY step 10 -> IDLE next cycle, out_valid never rises.
  - Drop rst_n mid-BUSY -> outputs read 0/1/0 immediately.
- WIDTH=8:
  - MUL 0x0F*0x11 -> 0xFF.
  - DIV 0x80/0xFF -> 0x80.
  - Latency 8 edges.
